// File: rtl/pcm_pkg.sv
// pcm_pkg
//   Definitions shared by the PCM memory manager, the per-core arbiter and
//   the per-CPU request registers in front of them.
//   - PCM_ADDR_W / PCM_DATA_W : default address and data widths
//   - pcm_req_state_t         : request-register FSM state (IDLE, SCHED)
package pcm_pkg;

    localparam int PCM_ADDR_W = 20;
    localparam int PCM_DATA_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SCHED = 1'b1
    } pcm_req_state_t;

endpackage : pcm_pkg

// File: rtl/pcm_mm_req_reg.sv
// pcm_mm_req_reg
//   Per-CPU request register between one CPU port and the shared PCM
//   memory-manager arbiter. A new CPU access is detected and its address
//   latched. schedule is raised until the arbiter reports resolved. The
//   result is then handed back to the CPU with cpu_ready.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   addr       in   [ADDR_W] CPU access address
//   cpu_write  in   1 = write access, 0 = read access
//   cpu_in     in   [DATA_W] CPU write data (sampled directly by the arbiter)
//   data_in    in   [DATA_W] read data from the memory manager
//   resolved   in   memory manager completed the scheduled request this cycle
//   schedule   out  request pending towards the arbiter
//   addr_reg   out  [ADDR_W] latched address of the current or last request
//   cpu_out    out  [DATA_W] data returned to the CPU
//   cpu_ready  out  last request done and still matches the CPU's access
//
// Handshake: schedule acts as the request valid. Once raised it stays high,
// with addr_reg and the latched direction stable, until a cycle in which
// resolved=1; that edge retires the request. resolved outside a pending
// request carries no meaning and is ignored. cpu_ready then stays high for
// as long as the CPU keeps presenting the same address and direction.
module pcm_mm_req_reg
    import pcm_pkg::*;
#(
    parameter int ADDR_W = PCM_ADDR_W,
    parameter int DATA_W = PCM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              resolved,
    output logic              schedule,
    output logic [ADDR_W-1:0] addr_reg,
    output logic [DATA_W-1:0] cpu_out,
    output logic              cpu_ready
);

    pcm_req_state_t state_q;
    pcm_req_state_t state_d;

    logic              valid_q;
    logic              wr_reg_q;
    logic              new_req;

    logic              valid_d;
    logic              wr_reg_d;
    logic              schedule_d;
    logic              cpu_ready_d;
    logic [ADDR_W-1:0] addr_reg_d;
    logic [DATA_W-1:0] cpu_out_d;

    // valid_q forces the first access after reset to be scheduled, even if
    // it targets address 0 as a read (which would otherwise match the
    // reset values of addr_reg / wr_reg).
    assign new_req = !valid_q || (addr != addr_reg) || (cpu_write != wr_reg_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (new_req)  state_d = SCHED;
            SCHED:   if (resolved) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and latches.
    // Everything holds by default, so an IDLE cycle with a repeated access
    // keeps returning the cached result without memory traffic.
    always_comb begin
        valid_d     = valid_q;
        wr_reg_d    = wr_reg_q;
        schedule_d  = schedule;
        cpu_ready_d = cpu_ready;
        addr_reg_d  = addr_reg;
        cpu_out_d   = cpu_out;
        case (state_q)
            IDLE: begin
                if (new_req) begin
                    addr_reg_d  = addr;
                    wr_reg_d    = cpu_write;
                    valid_d     = 1'b1;
                    schedule_d  = 1'b1;
                    cpu_ready_d = 1'b0;
                end
            end
            SCHED: begin
                // Input changes while pending are deliberately not looked at;
                // they are picked up by new_req in the following IDLE cycle.
                if (resolved) begin
                    schedule_d  = 1'b0;
                    cpu_ready_d = 1'b1;
                    // A write echoes the value the CPU wrote.
                    cpu_out_d   = wr_reg_q ? cpu_in : data_in;
                end
            end
            default: ;
        endcase
    end

    // Output and latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            wr_reg_q  <= 1'b0;
            schedule  <= 1'b0;
            cpu_ready <= 1'b0;
            addr_reg  <= '0;
            cpu_out   <= '0;
        end else begin
            valid_q   <= valid_d;
            wr_reg_q  <= wr_reg_d;
            schedule  <= schedule_d;
            cpu_ready <= cpu_ready_d;
            addr_reg  <= addr_reg_d;
            cpu_out   <= cpu_out_d;
        end
    end

endmodule : pcm_mm_req_reg

// File: tb/tb_pcm_mm_req_reg.sv
// tb_pcm_mm_req_reg
//   Table of {inputs, expected outputs} records applied one clock edge each,
//   plus hand-written reset sequences. Expected outputs are pushed to exp_q
//   when a record is driven and popped when the outputs are sampled.
module tb_pcm_mm_req_reg;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int EW = 2 + DW + AW;   // {schedule, cpu_ready, cpu_out, addr_reg}

    typedef struct {
        string          name;
        logic [AW-1:0]  addr;
        logic           wr;
        logic [DW-1:0]  cin;
        logic [DW-1:0]  din;
        logic           res;
        logic           e_sched;
        logic           e_ready;
        logic [DW-1:0]  e_out;
        logic [AW-1:0]  e_addr;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          reset;
    logic [AW-1:0] addr;
    logic          cpu_write;
    logic [DW-1:0] cpu_in;
    logic [DW-1:0] data_in;
    logic          resolved;
    logic          schedule;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] cpu_out;
    logic          cpu_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pcm_mm_req_reg #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .cpu_write (cpu_write),
        .cpu_in    (cpu_in),
        .data_in   (data_in),
        .resolved  (resolved),
        .schedule  (schedule),
        .addr_reg  (addr_reg),
        .cpu_out   (cpu_out),
        .cpu_ready (cpu_ready)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            check_cnt = 0;
    int            pass_cnt  = 0;
    vec_t          vecs[$];

    function automatic void add(string name, logic [AW-1:0] a, logic w, logic [DW-1:0] ci,
                                logic [DW-1:0] di, logic r, logic es, logic er,
                                logic [DW-1:0] eo, logic [AW-1:0] ea);
        vec_t v;
        v.name = name; v.addr = a; v.wr = w; v.cin = ci; v.din = di; v.res = r;
        v.e_sched = es; v.e_ready = er; v.e_out = eo; v.e_addr = ea;
        vecs.push_back(v);
    endfunction

    task automatic expect_out(logic es, logic er, logic [DW-1:0] eo, logic [AW-1:0] ea);
        exp_q.push_back({es, er, eo, ea});
    endtask

    task automatic check(string name);
        logic [EW-1:0] e;
        check_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: no expected entry queued, got sched=%0b ready=%0b out=%h addr_reg=%h",
                     name, schedule, cpu_ready, cpu_out, addr_reg);
        end else begin
            e = exp_q.pop_front();
            if ({schedule, cpu_ready, cpu_out, addr_reg} === e) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got sched=%0b ready=%0b out=%h addr_reg=%h, want sched=%0b ready=%0b out=%h addr_reg=%h",
                         name, schedule, cpu_ready, cpu_out, addr_reg,
                         e[EW-1], e[EW-2], e[AW+DW-1:AW], e[AW-1:0]);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(vec_t v);
        @(negedge clk);
        addr      = v.addr;
        cpu_write = v.wr;
        cpu_in    = v.cin;
        data_in   = v.din;
        resolved  = v.res;
        expect_out(v.e_sched, v.e_ready, v.e_out, v.e_addr);
        @(posedge clk);
        #1;
        check(v.name);
    endtask

    // ---------------- test ----------------
    initial begin
        // Vector table (applied after reset release and the first capture).
        add("rd0_done",     20'h00000, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h1234, 20'h00000);
        add("rd_ff_req",    20'hFFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1234, 20'hFFFFF);
        add("rd_ff_done",   20'hFFFFF, 1'b0, 16'h0000, 16'h0FF0, 1'b1, 1'b0, 1'b1, 16'h0FF0, 20'hFFFFF);
        // Repeated access: cached, and resolved while IDLE must be ignored.
        for (int i = 0; i < 10; i++)
            add("hold_ff",  20'hFFFFF, 1'b0, 16'h0000, 16'hDEAD, (i % 3) == 0,
                1'b0, 1'b1, 16'h0FF0, 20'hFFFFF);
        add("rd_10_req",    20'h00010, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0FF0, 20'h00010);
        add("rd_10_done",   20'h00010, 1'b0, 16'h0000, 16'h5555, 1'b1, 1'b0, 1'b1, 16'h5555, 20'h00010);
        add("wr_req",       20'h00010, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5555, 20'h00010);
        add("wr_wait_chg",  20'h00020, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5555, 20'h00010);
        add("wr_wait2",     20'h00010, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5555, 20'h00010);
        add("wr_done",      20'h00010, 1'b1, 16'hBEEF, 16'h7777, 1'b1, 1'b0, 1'b1, 16'hBEEF, 20'h00010);
        add("wr_repeat",    20'h00010, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF, 20'h00010);
        add("rd_after_wr",  20'h00010, 1'b0, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hBEEF, 20'h00010);
        add("rd_aw_done",   20'h00010, 1'b0, 16'hBEEF, 16'h0A0A, 1'b1, 1'b0, 1'b1, 16'h0A0A, 20'h00010);
        add("rd_30_req",    20'h00030, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0A0A, 20'h00030);

        // Power-on reset: outputs 0 immediately and while reset is held.
        reset = 1'b1; addr = '0; cpu_write = 1'b0; cpu_in = '0; data_in = '0; resolved = 1'b0;
        #1;
        expect_out(1'b0, 1'b0, 16'h0000, 20'h00000);
        check("reset_state");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            expect_out(1'b0, 1'b0, 16'h0000, 20'h00000);
            check("reset_held");
        end

        // Release: first access (address 0 read) is scheduled on the next edge.
        @(negedge clk);
        reset = 1'b0;
        expect_out(1'b1, 1'b0, 16'h0000, 20'h00000);
        @(posedge clk);
        #1;
        check("first_after_reset");

        foreach (vecs[i]) apply(vecs[i]);

        // Reset while a request is pending: drops without a clock edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_out(1'b0, 1'b0, 16'h0000, 20'h00000);
        check("reset_mid_sched");

        @(negedge clk);
        reset = 1'b0; addr = '0; cpu_write = 1'b0; resolved = 1'b0;
        expect_out(1'b1, 1'b0, 16'h0000, 20'h00000);
        @(posedge clk);
        #1;
        check("addr0_after_reset");

        begin
            vec_t v;
            v.name = "addr0_done"; v.addr = 20'h00000; v.wr = 1'b0; v.cin = 16'h0000;
            v.din = 16'hC3C3; v.res = 1'b1; v.e_sched = 1'b0; v.e_ready = 1'b1;
            v.e_out = 16'hC3C3; v.e_addr = 20'h00000;
            apply(v);
        end

        if (exp_q.size() != 0) begin
            check_cnt++;
            $display("FAIL leftover_expected: %0d entries left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_pcm_mm_req_reg
